// File: rtl/tick_stopwatch_if.sv
// Stopwatch control/status bundle.
// LAP_CAPTURE_EN adds the lap request and lap register output.
interface tick_stopwatch_if;
  logic        TICK_CLK;
  logic        START;
  logic        STOP;
  logic        CLEAR;
  logic [15:0] BCD;
  logic        RUNNING;
  logic        TICK;
  logic        WRAP;
`ifdef LAP_CAPTURE_EN
  logic        LAP;
  logic [15:0] LAP_BCD;

  modport master (
    output TICK_CLK, START, STOP, CLEAR, LAP,
    input  BCD, RUNNING, TICK, WRAP, LAP_BCD
  );
  modport slave (
    input  TICK_CLK, START, STOP, CLEAR, LAP,
    output BCD, RUNNING, TICK, WRAP, LAP_BCD
  );
`else
  modport master (
    output TICK_CLK, START, STOP, CLEAR,
    input  BCD, RUNNING, TICK, WRAP
  );
  modport slave (
    input  TICK_CLK, START, STOP, CLEAR,
    output BCD, RUNNING, TICK, WRAP
  );
`endif
endinterface

// File: rtl/tick_stopwatch.sv
// BCD stopwatch counting rising edges of a sampled slow clock.
// Optional lap register enabled by defining LAP_CAPTURE_EN.
module tick_stopwatch #(
  parameter int SYNC_STAGES = 2,
  parameter int WRAP_VALUE  = 9999
) (
  input logic             CLK_in,
  input logic             RST,
  tick_stopwatch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10),
              4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  localparam logic [15:0] WRAP_BCD = to_bcd(WRAP_VALUE);

  state_t                 state;
  state_t                 nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES:0]   fill;
  logic                   prev;
  logic                   rise;
  logic                   inc;
  logic                   at_wrap;
  logic                   carry;
  logic [3:0]             dig;
  logic [15:0]            bcd_inc;
  logic [15:0]            bcd_next;
  logic [15:0]            bcd_q;
  logic                   running_q;
  logic                   tick_q;
  logic                   wrap_q;

  // fill marks when prev holds a real post-reset sample, so a level
  // already high at reset release never looks like a rising edge
  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      sync <= '0;
      prev <= 1'b0;
      fill <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.TICK_CLK};
      prev <= sync[SYNC_STAGES-1];
      fill <= {fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~prev & fill[SYNC_STAGES];

  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (bus.CLEAR) begin
      nxt = IDLE;
    end else if (bus.STOP) begin
      if (state == RUN) nxt = PAUSE;
    end else if (bus.START) begin
      nxt = RUN;
    end
  end

  assign inc     = (state == RUN) & rise & ~bus.CLEAR;
  assign at_wrap = (bcd_q == WRAP_BCD);

  always_comb begin
    bcd_inc = bcd_q;
    carry   = 1'b1;
    dig     = '0;
    for (int i = 0; i < 4; i++) begin
      dig = bcd_q[4*i +: 4];
      if (carry) begin
        if (dig == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = dig + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_comb begin
    bcd_next = bcd_q;
    if (bus.CLEAR)    bcd_next = '0;
    else if (inc)     bcd_next = at_wrap ? '0 : bcd_inc;
  end

  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      bcd_q     <= '0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      bcd_q     <= bcd_next;
      running_q <= (nxt == RUN);
      tick_q    <= rise;
      wrap_q    <= inc & at_wrap;
    end
  end

  assign bus.BCD     = bcd_q;
  assign bus.RUNNING = running_q;
  assign bus.TICK    = tick_q;
  assign bus.WRAP    = wrap_q;

`ifdef LAP_CAPTURE_EN
  logic [15:0] lap_q;

  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST)                             lap_q <= '0;
    else if (bus.CLEAR)                  lap_q <= '0;
    else if (bus.LAP && state == RUN)    lap_q <= bcd_next;
  end

  assign bus.LAP_BCD = lap_q;
`endif

endmodule

// File: tb/tb_tick_stopwatch.sv
// Directed bench for tick_stopwatch with a tick scoreboard.
// Lap checks build only when LAP_CAPTURE_EN is defined.
module tb_tick_stopwatch;

  localparam int SS = 2;

  typedef struct {
    int          cyc;
    logic [15:0] bcd;
    logic        wrap;
  } exp_t;

  logic CLK_in = 1'b0;
  logic RST;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt = 0;
  bit   run_m = 0;
  exp_t q[$];
  exp_t mon_e;

  tick_stopwatch_if bus ();

  tick_stopwatch #(
    .SYNC_STAGES(SS),
    .WRAP_VALUE (9999)
  ) dut (
    .CLK_in(CLK_in),
    .RST   (RST),
    .bus   (bus)
  );

  always #5 CLK_in = ~CLK_in;
  always @(posedge CLK_in) cyc <= cyc + 1;

  function automatic logic [15:0] to_bcd(input int v);
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'(v / 1000 % 10);
    d2 = 4'(v / 100 % 10);
    d1 = 4'(v / 10 % 10);
    d0 = 4'(v % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  always @(negedge CLK_in) begin
    if (RST !== 1'b1) begin
      if (bus.TICK === 1'b1) begin
        n_cmp++;
        assert (q.size() != 0) else begin
          n_bad++;
          $error("FAIL tick_unexpected: observed TICK=1 expected 0 at cyc %0d", cyc);
        end
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          chk("tick_cycle", cyc, mon_e.cyc);
          chk("tick_bcd", bus.BCD, mon_e.bcd);
          chk("tick_wrap", bus.WRAP, mon_e.wrap);
        end
      end else begin
        chk("wrap_idle", bus.WRAP, 0);
      end
    end
  end

  task automatic rise(input int hi, input int lo, input bit stop_edge);
    exp_t e;
    bit   w;
    @(negedge CLK_in);
    bus.TICK_CLK = 1'b1;
    w = 1'b0;
    if (run_m) begin
      w   = (cnt == 9999);
      cnt = w ? 0 : cnt + 1;
    end
    e.cyc  = cyc + SS + 1;
    e.bcd  = to_bcd(cnt);
    e.wrap = w;
    q.push_back(e);
    if (stop_edge) begin
      repeat (SS) @(negedge CLK_in);
      bus.STOP = 1'b1;
      @(negedge CLK_in);
      bus.STOP = 1'b0;
      run_m = 1'b0;
      repeat (hi - SS - 1) @(negedge CLK_in);
    end else begin
      repeat (hi) @(negedge CLK_in);
    end
    bus.TICK_CLK = 1'b0;
    repeat (lo - 1) @(negedge CLK_in);
  endtask

  task automatic pulse_start();
    @(negedge CLK_in);
    bus.START = 1'b1;
    @(negedge CLK_in);
    bus.START = 1'b0;
    run_m = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: observed no finish expected finish by 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    RST          = 1'b1;
    bus.TICK_CLK = 1'b0;
    bus.START    = 1'b0;
    bus.STOP     = 1'b0;
    bus.CLEAR    = 1'b0;
`ifdef LAP_CAPTURE_EN
    bus.LAP      = 1'b0;
`endif

    // reset holds everything low while TICK_CLK toggles
    repeat (10) begin
      @(negedge CLK_in);
      bus.TICK_CLK = ~bus.TICK_CLK;
      chk("reset_out", {bus.BCD, bus.RUNNING, bus.TICK, bus.WRAP}, 0);
    end
    @(negedge CLK_in);
    bus.TICK_CLK = 1'b0;
    RST = 1'b0;
    repeat (4) @(negedge CLK_in);

    // latency and basic count
    pulse_start();
    chk("run_after_start", bus.RUNNING, 1);
    repeat (12) rise(50, 50, 1'b0);
    chk("bcd_12", bus.BCD, 16'h0012);

    // stop on the edge cycle: that tick counts
    rise(50, 50, 1'b1);
    chk("stop_running", bus.RUNNING, 0);
    chk("stop_final_tick", bus.BCD, 16'h0013);
    repeat (5) rise(50, 50, 1'b0);
    chk("pause_hold", bus.BCD, 16'h0013);
    pulse_start();
    chk("resume_running", bus.RUNNING, 1);
    repeat (3) rise(50, 50, 1'b0);
    chk("resume_count", bus.BCD, 16'h0016);

    // run up to the wrap point with a fast tick clock
    while (cnt != 9999) rise(2, 2, 1'b0);
    chk("bcd_9999", bus.BCD, 16'h9999);
    rise(2, 2, 1'b0);
    repeat (2) @(negedge CLK_in);
    chk("wrap_zero", bus.BCD, 16'h0000);

    // priority: CLEAR beats STOP and START
    repeat (2) rise(2, 2, 1'b0);
    chk("pre_clear", bus.BCD, 16'h0002);
    @(negedge CLK_in);
    bus.START = 1'b1;
    bus.STOP  = 1'b1;
    bus.CLEAR = 1'b1;
    @(negedge CLK_in);
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
    bus.CLEAR = 1'b0;
    cnt   = 0;
    run_m = 1'b0;
    chk("clear_running", bus.RUNNING, 0);
    chk("clear_bcd", bus.BCD, 16'h0000);
    rise(4, 4, 1'b0);
    chk("idle_hold", bus.BCD, 16'h0000);

    // STOP beats START in RUN
    pulse_start();
    @(negedge CLK_in);
    bus.START = 1'b1;
    bus.STOP  = 1'b1;
    @(negedge CLK_in);
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
    run_m = 1'b0;
    chk("stop_over_start", bus.RUNNING, 0);
    rise(4, 4, 1'b0);
    chk("paused_hold", bus.BCD, 16'h0000);
    pulse_start();
    rise(4, 4, 1'b0);
    chk("paused_resume", bus.BCD, 16'h0001);

    // reset mid-count with TICK_CLK already high
    @(negedge CLK_in);
    RST = 1'b1;
    bus.TICK_CLK = 1'b1;
    cnt   = 0;
    run_m = 1'b0;
    #1;
    chk("async_reset_bcd", bus.BCD, 16'h0000);
    repeat (3) @(negedge CLK_in);
    RST = 1'b0;
    repeat (10) @(negedge CLK_in);
    chk("post_reset_bcd", bus.BCD, 16'h0000);
    chk("post_reset_run", bus.RUNNING, 0);
    bus.TICK_CLK = 1'b0;
    repeat (3) @(negedge CLK_in);
    pulse_start();
    rise(4, 4, 1'b0);
    chk("post_reset_count", bus.BCD, 16'h0001);

`ifdef LAP_CAPTURE_EN
    while (cnt != 42) rise(2, 2, 1'b0);
    @(negedge CLK_in);
    bus.LAP = 1'b1;
    @(negedge CLK_in);
    bus.LAP = 1'b0;
    chk("lap_capture", bus.LAP_BCD, 16'h0042);
    repeat (3) rise(2, 2, 1'b0);
    chk("lap_hold", bus.LAP_BCD, 16'h0042);
    chk("lap_bcd_runs", bus.BCD, 16'h0045);
    @(negedge CLK_in);
    bus.CLEAR = 1'b1;
    @(negedge CLK_in);
    bus.CLEAR = 1'b0;
    cnt   = 0;
    run_m = 1'b0;
    chk("lap_clear", bus.LAP_BCD, 16'h0000);
`endif

    repeat (6) @(negedge CLK_in);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
